mem_port_arbiter: RTL and testbench

- Shares one single-port unified memory between the fetch stage (instruction read) and the memory stage (data load/store) of the pipelined core.
- Serialises requests through a fixed-latency memory access FSM and returns a one-cycle ack with read data.
- Generates stall_f and stall_m to the hazard unit so that the fetch and memory stages hold while their access is outstanding.
- Data requests win over fetch requests, because the data access belongs to the older instruction.

---
 rtl/mem_port_arbiter_if.sv | 45 ++++
 rtl/mem_port_arbiter.sv | 190 +++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - core/memory side signal bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int WIDTH      = 32,
    parameter int ADDR_WIDTH = 32
);
    logic                  if_req;
    logic [ADDR_WIDTH-1:0] if_addr;
    logic [WIDTH-1:0]      if_rdata;
    logic                  if_ack;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_WIDTH-1:0] d_addr;
    logic [WIDTH-1:0]      d_wdata;
    logic [2:0]            d_mode;
    logic [WIDTH-1:0]      d_rdata;
    logic                  d_ack;

    logic                  mem_en;
    logic                  mem_we;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [WIDTH-1:0]      mem_wdata;
    logic [2:0]            mem_mode;
    logic [WIDTH-1:0]      mem_rdata;

    logic                  stall_f;
    logic                  stall_m;
    logic                  busy;

    // Environment view: pipeline stages plus the memory array
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_rdata,
        input  if_rdata, if_ack, d_rdata, d_ack,
        input  mem_en, mem_we, mem_addr, mem_wdata, mem_mode,
        input  stall_f, stall_m, busy
    );

    // Arbiter view
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_mode, mem_rdata,
        output if_rdata, if_ack, d_rdata, d_ack,
        output mem_en, mem_we, mem_addr, mem_wdata, mem_mode,
        output stall_f, stall_m, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter for one single-port memory; optional starvation guard via ARB_STARVE_GUARD_EN
module mem_port_arbiter #(
    parameter int WIDTH        = 32,
    parameter int ADDR_WIDTH   = 32,
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4
) (
    input logic               clk,
    input logic               rst,
    mem_port_arbiter_if.slave bus
);
    localparam int               CNT_W     = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam logic [CNT_W-1:0] LAT_LOAD  = CNT_W'(MEM_LATENCY - 1);
    localparam logic [2:0]       MODE_WORD = 3'b010;

    if (MEM_LATENCY < 1 || STARVE_LIMIT < 1) begin : g_bad_params
        $error("mem_port_arbiter: MEM_LATENCY and STARVE_LIMIT must be at least 1");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t state_q, state_n;

    // owner: 1 = data stage, 0 = fetch stage
    logic                  owner_q,     owner_n;
    logic [CNT_W-1:0]      lat_cnt_q,   lat_cnt_n;
    logic                  mem_en_q,    mem_en_n;
    logic                  mem_we_q,    mem_we_n;
    logic [ADDR_WIDTH-1:0] mem_addr_q,  mem_addr_n;
    logic [WIDTH-1:0]      mem_wdata_q, mem_wdata_n;
    logic [2:0]            mem_mode_q,  mem_mode_n;
    logic [WIDTH-1:0]      if_rdata_q,  if_rdata_n;
    logic [WIDTH-1:0]      d_rdata_q,   d_rdata_n;
    logic                  if_ack_q,    if_ack_n;
    logic                  d_ack_q,     d_ack_n;

    logic grant_d;
    logic grant_f;
    logic force_fetch;

`ifdef ARB_STARVE_GUARD_EN
    localparam int STARVE_W = ($clog2(STARVE_LIMIT + 1) > 3) ? $clog2(STARVE_LIMIT + 1) : 3;

    logic [STARVE_W-1:0] starve_cnt_q;

    assign force_fetch = bus.if_req & bus.d_req & (starve_cnt_q == STARVE_W'(STARVE_LIMIT));

    // Count data grants that left fetch waiting; a fetch grant restores its budget
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt_q <= '0;
        end else if (state_q == S_IDLE) begin
            if (grant_f) begin
                starve_cnt_q <= '0;
            end else if (grant_d && bus.if_req) begin
                starve_cnt_q <= starve_cnt_q + STARVE_W'(1);
            end
        end
    end
`else
    assign force_fetch = 1'b0;
`endif

    // Arbitration: data belongs to the older instruction and wins unless fetch is forced
    always_comb begin
        grant_d = bus.d_req & ~force_fetch;
        grant_f = bus.if_req & ~grant_d;
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state_q;
        unique case (state_q)
            S_IDLE:  if (grant_d || grant_f) state_n = S_ISSUE;
            S_ISSUE: state_n = S_WAIT;
            S_WAIT:  if (lat_cnt_q == '0) state_n = S_DONE;
            S_DONE:  state_n = S_IDLE;
            default: state_n = S_IDLE;
        endcase
    end

    // Output logic: next values of the registered outputs and request latches
    always_comb begin
        owner_n     = owner_q;
        lat_cnt_n   = lat_cnt_q;
        mem_en_n    = 1'b0;
        mem_we_n    = mem_we_q;
        mem_addr_n  = mem_addr_q;
        mem_wdata_n = mem_wdata_q;
        mem_mode_n  = mem_mode_q;
        if_rdata_n  = if_rdata_q;
        d_rdata_n   = d_rdata_q;
        if_ack_n    = 1'b0;
        d_ack_n     = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (grant_d) begin
                    owner_n     = 1'b1;
                    mem_en_n    = 1'b1;
                    mem_we_n    = bus.d_we;
                    mem_addr_n  = bus.d_addr;
                    mem_wdata_n = bus.d_wdata;
                    mem_mode_n  = bus.d_mode;
                end else if (grant_f) begin
                    owner_n     = 1'b0;
                    mem_en_n    = 1'b1;
                    mem_we_n    = 1'b0;
                    mem_addr_n  = bus.if_addr;
                    mem_wdata_n = '0;
                    mem_mode_n  = MODE_WORD;
                end
            end
            S_ISSUE: begin
                lat_cnt_n = LAT_LOAD;
            end
            S_WAIT: begin
                if (lat_cnt_q != '0) begin
                    lat_cnt_n = lat_cnt_q - CNT_W'(1);
                end else if (owner_q) begin
                    d_rdata_n = mem_we_q ? '0 : bus.mem_rdata;
                    d_ack_n   = 1'b1;
                end else begin
                    if_rdata_n = bus.mem_rdata;
                    if_ack_n   = 1'b1;
                end
            end
            S_DONE: begin
            end
            default: begin
            end
        endcase
    end

    // Output and latch registers
    always_ff @(posedge clk) begin
        if (rst) begin
            owner_q     <= 1'b0;
            lat_cnt_q   <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_mode_q  <= '0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            if_ack_q    <= 1'b0;
            d_ack_q     <= 1'b0;
        end else begin
            owner_q     <= owner_n;
            lat_cnt_q   <= lat_cnt_n;
            mem_en_q    <= mem_en_n;
            mem_we_q    <= mem_we_n;
            mem_addr_q  <= mem_addr_n;
            mem_wdata_q <= mem_wdata_n;
            mem_mode_q  <= mem_mode_n;
            if_rdata_q  <= if_rdata_n;
            d_rdata_q   <= d_rdata_n;
            if_ack_q    <= if_ack_n;
            d_ack_q     <= d_ack_n;
        end
    end

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mem_mode  = mem_mode_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.if_ack    = if_ack_q;
    assign bus.d_ack     = d_ack_q;

    assign bus.stall_f   = bus.if_req & ~if_ack_q;
    assign bus.stall_m   = bus.d_req & ~d_ack_q;
    assign bus.busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
    localparam logic [31:0] JUNK = 32'hBADC0DE0;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    mem_port_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus ();
    mem_port_arbiter_if #(.WIDTH(32), .ADDR_WIDTH(32)) bus1 ();

    mem_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(2), .STARVE_LIMIT(4)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    mem_port_arbiter #(.WIDTH(32), .ADDR_WIDTH(32), .MEM_LATENCY(1), .STARVE_LIMIT(4)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One isolated transaction on the MEM_LATENCY=2 port; cycle 0 is the request cycle
    task automatic run_single(input string tag, input bit is_data, input bit we,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [2:0] mode, input logic [31:0] rd);
        logic [2:0]  exp_mode;
        logic [31:0] exp_rdata;
        exp_mode  = is_data ? mode : 3'b010;
        exp_rdata = (is_data && we) ? 32'h0 : rd;
        for (int c = 0; c <= 5; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                if (is_data) begin
                    bus.d_req   = 1'b1;
                    bus.d_we    = we;
                    bus.d_addr  = addr;
                    bus.d_wdata = wdata;
                    bus.d_mode  = mode;
                end else begin
                    bus.if_req  = 1'b1;
                    bus.if_addr = addr;
                end
            end
            bus.mem_rdata = (c == 3) ? rd : JUNK;
            if (c == 5) begin
                bus.if_req = 1'b0;
                bus.d_req  = 1'b0;
            end
            @(negedge clk);
            check($sformatf("%s_mem_en_c%0d", tag, c), bus.mem_en, (c == 1));
            check($sformatf("%s_if_ack_c%0d", tag, c), bus.if_ack, (!is_data && c == 4));
            check($sformatf("%s_d_ack_c%0d", tag, c), bus.d_ack, (is_data && c == 4));
            check($sformatf("%s_stall_f_c%0d", tag, c), bus.stall_f, (!is_data && c <= 3));
            check($sformatf("%s_stall_m_c%0d", tag, c), bus.stall_m, (is_data && c <= 3));
            check($sformatf("%s_busy_c%0d", tag, c), bus.busy, (c >= 1 && c <= 4));
            if (c == 1) begin
                check({tag, "_mem_addr"}, bus.mem_addr, addr);
                check({tag, "_mem_we"}, bus.mem_we, we);
                check({tag, "_mem_mode"}, bus.mem_mode, exp_mode);
                if (is_data) check({tag, "_mem_wdata"}, bus.mem_wdata, wdata);
            end
            if (c == 4) begin
                if (is_data) check({tag, "_d_rdata"}, bus.d_rdata, exp_rdata);
                else         check({tag, "_if_rdata"}, bus.if_rdata, exp_rdata);
            end
        end
    endtask

    initial begin
        bit kinds[8];
        int n_ack;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.if_req = 0; bus.if_addr = 0; bus.d_req = 0; bus.d_we = 0;
        bus.d_addr = 0; bus.d_wdata = 0; bus.d_mode = 0; bus.mem_rdata = 0;
        bus1.if_req = 0; bus1.if_addr = 0; bus1.d_req = 0; bus1.d_we = 0;
        bus1.d_addr = 0; bus1.d_wdata = 0; bus1.d_mode = 0; bus1.mem_rdata = 0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_mem_en", bus.mem_en, 0);
        check("rst_acks", {bus.if_ack, bus.d_ack}, 0);
        check("rst_rdata", {bus.if_rdata, bus.d_rdata}, 0);
        check("rst_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_mode}, 0);
        check("rst_busy1", bus1.busy, 0);

        // Fetch, load, then store (store must clear the stale load data)
        run_single("fetch", 1'b0, 1'b0, 32'h40, 32'h0, 3'b000, 32'h00500093);
        run_single("load", 1'b1, 1'b0, 32'h2000, 32'h0, 3'b100, 32'h12345678);
        run_single("store", 1'b1, 1'b1, 32'h1000, 32'hDEADBEEF, 3'b010, 32'h5A5A5A5A);

        // Simultaneous requests: data first, fetch granted in cycle 5
        for (int c = 0; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.if_req = 1'b1; bus.if_addr = 32'h80;
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h3000; bus.d_mode = 3'b010;
            end
            if (c == 5)  bus.d_req = 1'b0;
            if (c == 10) bus.if_req = 1'b0;
            bus.mem_rdata = (c == 3) ? 32'hAAAA5555 : (c == 8) ? 32'h11112222 : JUNK;
            @(negedge clk);
            check($sformatf("both_d_ack_c%0d", c), bus.d_ack, (c == 4));
            check($sformatf("both_if_ack_c%0d", c), bus.if_ack, (c == 9));
            check($sformatf("both_stall_f_c%0d", c), bus.stall_f, (c <= 8));
            check($sformatf("both_stall_m_c%0d", c), bus.stall_m, (c <= 3));
            check($sformatf("both_mem_en_c%0d", c), bus.mem_en, (c == 1 || c == 6));
            if (c == 1) check("both_addr_data", bus.mem_addr, 32'h3000);
            if (c == 6) check("both_addr_fetch", bus.mem_addr, 32'h80);
            if (c == 4) check("both_d_rdata", bus.d_rdata, 32'hAAAA5555);
            if (c == 9) check("both_if_rdata", bus.if_rdata, 32'h11112222);
        end

        // Reset in cycle 2 of a load
        for (int c = 0; c <= 7; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h4000; bus.d_mode = 3'b001;
            end
            if (c == 2) rst = 1'b1;
            if (c == 3) bus.d_req = 1'b0;
            if (c == 4) rst = 1'b0;
            bus.mem_rdata = JUNK;
            @(negedge clk);
            if (c == 1) check("rstmid_mem_addr_c1", bus.mem_addr, 32'h4000);
            if (c == 3) begin
                check("rstmid_busy", bus.busy, 0);
                check("rstmid_mem_en", bus.mem_en, 0);
                check("rstmid_mem_bus", {bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.mem_mode}, 0);
                check("rstmid_rdata", {bus.if_rdata, bus.d_rdata}, 0);
                check("rstmid_stalls", {bus.stall_f, bus.stall_m}, 0);
            end
            if (c >= 3) begin
                check($sformatf("rstmid_d_ack_c%0d", c), bus.d_ack, 0);
                check($sformatf("rstmid_idle_c%0d", c), bus.busy, 0);
            end
        end

        // MEM_LATENCY=1: held request gives back-to-back loads acked in cycles 3 and 7
        for (int c = 0; c <= 8; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus1.d_req = 1'b1; bus1.d_we = 1'b0; bus1.d_addr = 32'h500; bus1.d_mode = 3'b010;
            end
            if (c == 4) bus1.d_addr = 32'h504;
            if (c == 8) bus1.d_req = 1'b0;
            bus1.mem_rdata = (c == 2) ? 32'hCAFE0001 : (c == 6) ? 32'hCAFE0002 : JUNK;
            @(negedge clk);
            check($sformatf("lat1_d_ack_c%0d", c), bus1.d_ack, (c == 3 || c == 7));
            check($sformatf("lat1_mem_en_c%0d", c), bus1.mem_en, (c == 1 || c == 5));
            if (c == 1) check("lat1_addr_a", bus1.mem_addr, 32'h500);
            if (c == 5) check("lat1_addr_b", bus1.mem_addr, 32'h504);
            if (c == 3) check("lat1_rdata_a", bus1.d_rdata, 32'hCAFE0001);
            if (c == 7) check("lat1_rdata_b", bus1.d_rdata, 32'hCAFE0002);
        end

        // Both requests held continuously for eight access slots
        n_ack = 0;
        for (int c = 0; c <= 39; c++) begin
            @(posedge clk);
            #1;
            if (c == 0) begin
                bus.if_req = 1'b1; bus.if_addr = 32'h100;
                bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 32'h6000; bus.d_mode = 3'b010;
            end
            bus.mem_rdata = JUNK;
            @(negedge clk);
            if (bus.if_ack && bus.d_ack) check($sformatf("held_dual_ack_c%0d", c), 1, 0);
            if (bus.if_ack || bus.d_ack) begin
                if (n_ack < 8) kinds[n_ack] = bus.if_ack;
                n_ack++;
            end
        end
        check("held_ack_count", n_ack, 8);
        for (int i = 0; i < 8; i++) begin
`ifdef ARB_STARVE_GUARD_EN
            check($sformatf("held_ack%0d_is_fetch", i), kinds[i], (i == 4));
`else
            check($sformatf("held_ack%0d_is_fetch", i), kinds[i], 0);
`endif
        end
`ifndef ARB_STARVE_GUARD_EN
        check("held_stall_f_end", bus.stall_f, 1);
`endif
        @(posedge clk);
        #1;
        bus.if_req = 1'b0;
        bus.d_req  = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
